// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter
// ----------------
// Round-robin arbiter that shares the MiniRISC data memory bus among
// NUM_MASTERS requesters (CPU, debug, DMA, ...). The master holding the
// grant has its address, write data and rd/wr strobes steered
// combinationally onto the single memory port.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> an owner that has held the bus for MAX_HOLD cycles is
//                pre-empted when any other master is requesting.
//   undefined -> an owner keeps the bus while its request stays high.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   m_req_i        per-master request, held until transfer done
//   m_grant_o      one-hot grant (at most one bit high)
//   m_addr_i       packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   m_wr_data_i    packed write data, same packing as m_addr_i
//   m_wr_i         per-master write strobe
//   m_rd_i         per-master read strobe
//   bus_addr_o     address to data memory
//   bus_wr_data_o  write data to data memory
//   bus_wr_o       memory write enable
//   bus_rd_o       memory read enable
//   bus_owner_o    registered owner index, meaningful while bus_busy_o = 1
//   bus_busy_o     a grant is currently active
module data_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_HOLD    = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_req_i,
    output logic [NUM_MASTERS-1:0]            m_grant_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wr_data_i,
    input  logic [NUM_MASTERS-1:0]            m_wr_i,
    input  logic [NUM_MASTERS-1:0]            m_rd_i,
    output logic [ADDR_WIDTH-1:0]             bus_addr_o,
    output logic [DATA_WIDTH-1:0]             bus_wr_data_o,
    output logic                              bus_wr_o,
    output logic                              bus_rd_o,
    output logic [$clog2(NUM_MASTERS)-1:0]    bus_owner_o,
    output logic                              bus_busy_o
);

    localparam int OW = $clog2(NUM_MASTERS);
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [OW:0]   NM_W      = (OW+1)'(NUM_MASTERS);
    localparam logic [OW-1:0] LAST_INIT = OW'(NUM_MASTERS-1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD-1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q, last_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

    logic [ADDR_WIDTH-1:0] addr_arr    [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] wr_data_arr [NUM_MASTERS];

    logic [OW:0]     scan_sum;
    logic [OW-1:0]   scan_idx;
    logic            win_any;
    logic [OW-1:0]   win_idx;
`ifdef ARB_TIMEOUT_EN
    logic            alt_any;
    logic [OW-1:0]   alt_idx;
`endif
    logic            grant_act;

    // Unpack the flat per-master buses so the mux can index by owner.
    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign addr_arr[g]    = m_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wr_data_arr[g] = m_wr_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Rotating priority search starting just after the last winner.
    // The sum never exceeds 2*NUM_MASTERS-1, so one conditional subtract
    // is enough to wrap it. The alternate search skips the current owner
    // and is used for time-out pre-emption.
    always_comb begin
        scan_sum = '0;
        scan_idx = '0;
        win_any  = 1'b0;
        win_idx  = '0;
`ifdef ARB_TIMEOUT_EN
        alt_any  = 1'b0;
        alt_idx  = '0;
`endif
        for (int k = 0; k < NUM_MASTERS; k++) begin
            scan_sum = {1'b0, last_q} + (OW+1)'(k + 1);
            if (scan_sum >= NM_W) begin
                scan_sum = scan_sum - NM_W;
            end
            scan_idx = scan_sum[OW-1:0];
            if (m_req_i[scan_idx] && !win_any) begin
                win_any = 1'b1;
                win_idx = scan_idx;
            end
`ifdef ARB_TIMEOUT_EN
            if (m_req_i[scan_idx] && !alt_any && (scan_idx != owner_q)) begin
                alt_any = 1'b1;
                alt_idx = scan_idx;
            end
`endif
        end
    end

    // Next-state logic. An owner releasing the bus hands it straight to
    // the next requester without passing through IDLE; hold_cnt saturates
    // so a long transfer cannot wrap it back to zero.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d    = OWNED;
                    owner_d    = win_idx;
                    last_d     = win_idx;
                    hold_cnt_d = '0;
                end
            end
            OWNED: begin
                if (!m_req_i[owner_q]) begin
                    if (win_any) begin
                        owner_d    = win_idx;
                        last_d     = win_idx;
                        hold_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if ((hold_cnt_q == HOLD_MAX) && alt_any) begin
                    owner_d    = alt_idx;
                    last_d     = alt_idx;
                    hold_cnt_d = '0;
                end
`endif
                else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; last starts at the top index
    // so master 0 is first in line after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= LAST_INIT;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Grant and bus mux follow the owner's live request, so a dropped
    // request removes the grant and strobes in the same cycle.
    always_comb begin
        grant_act     = (state_q == OWNED) && m_req_i[owner_q];
        m_grant_o     = '0;
        bus_addr_o    = '0;
        bus_wr_data_o = '0;
        bus_wr_o      = 1'b0;
        bus_rd_o      = 1'b0;
        if (grant_act) begin
            m_grant_o[owner_q] = 1'b1;
            bus_addr_o         = addr_arr[owner_q];
            bus_wr_data_o      = wr_data_arr[owner_q];
            bus_wr_o           = m_wr_i[owner_q];
            bus_rd_o           = m_rd_i[owner_q];
        end
        bus_busy_o  = grant_act;
        bus_owner_o = (state_q == OWNED) ? owner_q : '0;
    end

endmodule
